bsg_manycore_link_retime_array: RTL and testbench

Parametrised array of elastic retiming pipelines for the horizontal and vertical boundary links of a manycore tile subarray. Each of `num_ch_p` independent valid/ready channels passes through `stages_p` two-entry elastic buffers, giving full throughput and a configurable number of register boundaries between subarrays. The block also carries a matching reset pipeline and per-channel occupancy reporting. It sits between adjacent compute subarrays or between a subarray and the vcache rows, so long boundary wires can be cut without changing tile logic.

---
 rtl/bsg_manycore_link_retime_array.sv | 79 +++++++
 tb/tb_bsg_manycore_link_retime_array.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_link_retime_array.sv
// bsg_manycore_link_retime_array: per-channel chains of 2-entry elastic buffers for subarray boundary links
// Ports: clk_i/reset_n_i (async active-low); v_i/data_i/ready_and_o upstream;
// v_o/data_o/ready_and_i downstream; reset_n_o delayed reset; occupancy_o words held per channel.
module bsg_manycore_link_retime_array #(
    parameter int width_p  = 32,
    parameter int num_ch_p = 1,
    parameter int stages_p = 1,
    localparam int occ_width_lp = (2*stages_p+1) > 1 ? $clog2(2*stages_p+1) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_ch_p-1:0]                    v_i,
    input  logic [num_ch_p-1:0][width_p-1:0]       data_i,
    output logic [num_ch_p-1:0]                    ready_and_o,
    output logic [num_ch_p-1:0]                    v_o,
    output logic [num_ch_p-1:0][width_p-1:0]       data_o,
    input  logic [num_ch_p-1:0]                    ready_and_i,
    output logic                                   reset_n_o,
    output logic [num_ch_p-1:0][occ_width_lp-1:0]  occupancy_o
);
    if (stages_p == 0) begin : g_pass
        assign v_o         = v_i;
        assign data_o      = data_i;
        assign ready_and_o = ready_and_i;
        assign occupancy_o = '0;
        assign reset_n_o   = reset_n_i;
    end else begin : g_pipe
        logic [stages_p-1:0] rst_r;
        // ones shift in after release; assertion clears the whole chain at once
        always_ff @(posedge clk_i or negedge reset_n_i)
            if (!reset_n_i) rst_r <= '0;
            else            rst_r <= (rst_r << 1) | stages_p'(1);
        assign reset_n_o = rst_r[stages_p-1];
        for (genvar c = 0; c < num_ch_p; c++) begin : g_ch
            logic                    v   [stages_p+1];
            logic                    rdy [stages_p+1];
            logic [width_p-1:0]      d   [stages_p+1];
            logic [1:0]              cnt [stages_p];
            logic [occ_width_lp-1:0] occ;
            assign v[0]            = v_i[c];
            assign d[0]            = data_i[c];
            assign rdy[stages_p]   = ready_and_i[c];
            assign v_o[c]          = v[stages_p];
            assign data_o[c]       = d[stages_p];
            assign ready_and_o[c]  = rdy[0];
            for (genvar s = 0; s < stages_p; s++) begin : g_st
                logic [1:0]         count_r, count_n;
                logic               ready_r, enq, deq;
                logic [width_p-1:0] head_r, tail_r;
                assign enq     = v[s] & ready_r;
                assign deq     = (count_r != 2'd0) & rdy[s+1];
                assign count_n = count_r + {1'b0, enq} - {1'b0, deq};
                // ready is a flop so it stays low through reset and never depends on downstream ready
                always_ff @(posedge clk_i or negedge reset_n_i)
                    if (!reset_n_i) begin
                        count_r <= '0;
                        ready_r <= 1'b0;
                    end else begin
                        count_r <= count_n;
                        ready_r <= count_n != 2'd2;
                    end
                always_ff @(posedge clk_i) begin
                    if (enq && (count_r == 2'd0 || (count_r == 2'd1 && deq))) head_r <= d[s];
                    else if (deq && count_r == 2'd2)                         head_r <= tail_r;
                    if (enq && count_r == 2'd1 && !deq)                      tail_r <= d[s];
                end
                assign rdy[s]   = ready_r;
                assign v[s+1]   = count_r != 2'd0;
                assign d[s+1]   = head_r;
                assign cnt[s]   = count_r;
            end
            always_comb begin
                occ = '0;
                for (int s = 0; s < stages_p; s++) occ = occ + occ_width_lp'(cnt[s]);
            end
            assign occupancy_o[c] = occ;
        end
    end
endmodule

// File: tb/tb_bsg_manycore_link_retime_array.sv
// tb_bsg_manycore_link_retime_array: queue-scoreboard bench for the retime array (3 stages) plus a pass-through instance
module tb_bsg_manycore_link_retime_array;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic             reset_n_i;
    logic [3:0]       v_i, ready_and_o, v_o, ready_and_i;
    logic [3:0][7:0]  data_i, data_o;
    logic             reset_n_o;
    logic [3:0][2:0]  occupancy_o;

    logic [3:0]       p_v, p_ro, p_vo, p_ri;
    logic [3:0][7:0]  p_d, p_do;
    logic             p_rst;
    logic [3:0][0:0]  p_occ;

    bsg_manycore_link_retime_array #(.width_p(8), .num_ch_p(4), .stages_p(3)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
        .ready_and_o(ready_and_o), .v_o(v_o), .data_o(data_o), .ready_and_i(ready_and_i),
        .reset_n_o(reset_n_o), .occupancy_o(occupancy_o));

    bsg_manycore_link_retime_array #(.width_p(8), .num_ch_p(4), .stages_p(0)) u_pass (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(p_v), .data_i(p_d),
        .ready_and_o(p_ro), .v_o(p_vo), .data_o(p_do), .ready_and_i(p_ri),
        .reset_n_o(p_rst), .occupancy_o(p_occ));

    int n_checks = 0, n_errors = 0;
    logic [7:0] q [4][$];
    int n_acc [4], n_del [4];
    logic [3:0] acc, del;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock cycle: check state vs model, drive, check outputs, then commit transfers to the model
    task automatic step(input logic [3:0] vi, input logic [3:0] ri, input logic [3:0][7:0] di,
                        output logic [3:0] a, output logic [3:0] dl);
        @(negedge clk_i);
        for (int c = 0; c < 4; c++) check($sformatf("occ%0d", c), 32'(occupancy_o[c]), q[c].size());
        v_i = vi; ready_and_i = ri; data_i = di;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (q[c].size() >= 6) check($sformatf("full_ready%0d", c), 32'(ready_and_o[c]), 0);
            if (v_o[c]) begin
                check($sformatf("v_nonempty%0d", c), 32'(q[c].size() != 0), 1);
                if (q[c].size() != 0) check($sformatf("data%0d", c), 32'(data_o[c]), 32'(q[c][0]));
            end
        end
        a = v_i & ready_and_o;
        dl = v_o & ready_and_i;
        @(posedge clk_i);
        for (int c = 0; c < 4; c++) begin
            if (dl[c] && q[c].size() != 0) void'(q[c].pop_front());
            if (dl[c]) n_del[c]++;
            if (a[c]) begin
                q[c].push_back(di[c]);
                n_acc[c]++;
            end
        end
    endtask

    initial begin
        int w, first_k, base_acc, base_del;
        logic [3:0][7:0] di;
        for (int c = 0; c < 4; c++) begin n_acc[c] = 0; n_del[c] = 0; end
        reset_n_i = 1'b0; v_i = '0; ready_and_i = '0; data_i = '0;
        p_v = '0; p_d = '0; p_ri = '0;

        // reset values, release timing
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("rst_v", 32'(v_o), 0);
            check("rst_ready", 32'(ready_and_o), 0);
            check("rst_occ", 32'(occupancy_o), 0);
            check("rst_rn", 32'(reset_n_o), 0);
            check("pass_rst", 32'(p_rst), 32'(reset_n_i));
        end
        reset_n_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i);
            check($sformatf("rel_ready%0d", k), 32'(ready_and_o), 32'hf);
            check($sformatf("rel_rn%0d", k), 32'(reset_n_o), 32'(k >= 3));
        end
        check("pass_rst_hi", 32'(p_rst), 1);

        // pass-through is purely combinational
        for (int k = 0; k < 8; k++) begin
            p_v = 4'($urandom); p_d = $urandom; p_ri = 4'($urandom);
            #1;
            check("pass_v", 32'(p_vo), 32'(p_v));
            check("pass_d", p_do, p_d);
            check("pass_r", 32'(p_ro), 32'(p_ri));
            check("pass_occ", 32'(p_occ), 0);
        end

        // streaming on ch0
        w = 1; first_k = -1; base_del = n_del[0];
        for (int k = 0; k < 20; k++) begin
            di = '0; di[0] = 8'(w);
            step({3'b0, k < 16}, 4'hf, di, acc, del);
            if (acc[0]) w++;
            if (del[0] && first_k < 0) first_k = k;
            if (k == 10) begin
                #1;
                check("stream_occ", 32'(occupancy_o[0]), 3);
                check("stream_idle", 32'(occupancy_o[3:1]), 0);
            end
        end
        check("stream_lat", first_k, 3);
        check("stream_acc", w - 1, 16);
        check("stream_del", n_del[0] - base_del, 16);

        // backpressure fill on ch1
        w = 0; base_del = n_del[1];
        for (int k = 0; k < 12; k++) begin
            di = '0; di[1] = 8'(w);
            step({2'b0, w < 10, 1'b0}, 4'b1101, di, acc, del);
            if (acc[1]) w++;
        end
        check("bp_acc", w, 6);
        #1;
        check("bp_ready", 32'(ready_and_o[1]), 0);
        check("bp_occ", 32'(occupancy_o[1]), 6);
        for (int k = 0; k < 25; k++) begin
            di = '0; di[1] = 8'(w);
            step({2'b0, w < 10, 1'b0}, 4'hf, di, acc, del);
            if (acc[1]) w++;
        end
        check("bp_total_acc", w, 10);
        check("bp_total_del", n_del[1] - base_del, 10);

        // randomized handshake on all channels
        base_acc = n_acc[0] + n_acc[1] + n_acc[2] + n_acc[3];
        for (int k = 0; k < 10000; k++) step(4'($urandom), 4'($urandom), $urandom, acc, del);
        for (int k = 0; k < 40; k++) step(4'h0, 4'hf, '0, acc, del);
        for (int c = 0; c < 4; c++) check($sformatf("rand_drain%0d", c), q[c].size(), 0);
        check("rand_acc", 32'((n_acc[0] + n_acc[1] + n_acc[2] + n_acc[3] - base_acc) > 8000), 1);

        // mid-operation asynchronous reset with 4 words buffered on ch2
        w = 0;
        for (int k = 0; k < 10 && w < 4; k++) begin
            di = '0; di[2] = 8'(8'ha0 + w);
            step(4'b0100, 4'b1011, di, acc, del);
            if (acc[2]) w++;
        end
        @(negedge clk_i);
        check("mr_occ_pre", 32'(occupancy_o[2]), 4);
        check("mr_v_pre", 32'(v_o[2]), 1);
        #3 reset_n_i = 1'b0;
        #1;
        check("mr_v", 32'(v_o), 0);
        check("mr_occ", 32'(occupancy_o), 0);
        check("mr_ready", 32'(ready_and_o), 0);
        for (int c = 0; c < 4; c++) q[c].delete();
        v_i = '0; ready_and_i = '0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (4) @(posedge clk_i);
        base_del = n_del[2]; w = 0;
        for (int k = 0; k < 12; k++) begin
            di = '0; di[2] = 8'h5a;
            step({1'b0, w == 0, 2'b0}, 4'hf, di, acc, del);
            if (acc[2]) w++;
        end
        check("mr_new_acc", w, 1);
        check("mr_new_del", n_del[2] - base_del, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
